// File: rtl/cvxif_offload_agent.sv
// CV-X-IF core-side offload agent: issues undecodable instructions to a coprocessor,
// tracks them by ID, forwards commit/kill decisions and returns results to writeback.
package cvxif_pkg;
  localparam int X_NUM_RS    = 2;
  localparam int X_ID_WIDTH  = 3;
  localparam int X_RFR_WIDTH = 32;
  localparam int X_RFW_WIDTH = 32;
  localparam int X_MEM_WIDTH = 32;

  typedef struct packed {
    logic [15:0]           instr;
    logic [1:0]            mode;
    logic [X_ID_WIDTH-1:0] id;
  } x_compressed_req_t;

  typedef struct packed {
    logic [31:0] instr;
    logic        accept;
  } x_compressed_resp_t;

  typedef struct packed {
    logic [31:0]                           instr;
    logic [1:0]                            mode;
    logic [X_ID_WIDTH-1:0]                 id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0]  rs;
    logic [X_NUM_RS-1:0]                   rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
    logic dualwrite;
    logic dualread;
    logic loadstore;
    logic exc;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  commit_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [31:0]            addr;
    logic [1:0]             mode;
    logic                   we;
    logic [1:0]             size;
    logic [X_MEM_WIDTH-1:0] wdata;
    logic                   last;
    logic                   spec;
  } x_mem_req_t;

  typedef struct packed {
    logic       exc;
    logic [5:0] exccode;
  } x_mem_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_MEM_WIDTH-1:0] rdata;
    logic                   err;
  } x_mem_result_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef struct packed {
    logic               x_compressed_valid;
    x_compressed_req_t  x_compressed_req;
    logic               x_issue_valid;
    x_issue_req_t       x_issue_req;
    logic               x_commit_valid;
    x_commit_t          x_commit;
    logic               x_mem_ready;
    x_mem_resp_t        x_mem_resp;
    logic               x_mem_result_valid;
    x_mem_result_t      x_mem_result;
    logic               x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic               x_compressed_ready;
    x_compressed_resp_t x_compressed_resp;
    logic               x_issue_ready;
    x_issue_resp_t      x_issue_resp;
    logic               x_mem_valid;
    x_mem_req_t         x_mem_req;
    logic               x_result_valid;
    x_result_t          x_result;
  } cvxif_resp_t;
endpackage

module cvxif_offload_agent
  import cvxif_pkg::*;
#(
  parameter int NrOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 off_valid_i,
  output logic                                 off_ready_o,
  input  logic [31:0]                          off_instr_i,
  input  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] off_rs_i,
  output logic                                 off_resp_valid_o,
  output logic                                 off_resp_accept_o,
  output logic [X_ID_WIDTH-1:0]                off_resp_id_o,
  output logic                                 off_resp_writeback_o,
  input  logic                                 commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]                commit_id_i,
  input  logic                                 commit_kill_i,
  output logic                                 wb_valid_o,
  input  logic                                 wb_ready_i,
  output logic [X_ID_WIDTH-1:0]                wb_id_o,
  output logic [4:0]                           wb_rd_o,
  output logic [X_RFW_WIDTH-1:0]               wb_data_o,
  output logic                                 wb_we_o,
  output logic                                 wb_exc_o,
  output logic [5:0]                           wb_exccode_o,
  output logic                                 err_o,
  output cvxif_req_t                           cvxif_req_o,
  input  cvxif_resp_t                          cvxif_resp_i
);

  typedef enum logic {IDLE, ISSUE} state_e;

  state_e                   state_q, state_d;
  x_issue_req_t             issue_req_q, issue_req_d;
  logic [NrOutstanding-1:0] valid_q, valid_d, wb_q, wb_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_accept_q, resp_accept_d;
  logic                     resp_wb_q, resp_wb_d;
  logic [X_ID_WIDTH-1:0]    resp_id_q, resp_id_d;
  logic                     commit_valid_q;
  x_commit_t                commit_q;
  logic                     err_q, err_d;

  x_result_t                res;
  logic [NrOutstanding-1:0] res_sel, cmt_sel, iss_sel;
  logic [X_ID_WIDTH-1:0]    alloc_id;
  logic                     any_free, res_hs, kill_now, kill_hit;
  logic                     res_entry_valid, cmt_entry_valid, res_deliver;

  assign res = cvxif_resp_i.x_result;

  // One-hot decodes; IDs beyond the table decode to nothing and so look invalid.
  for (genvar i = 0; i < NrOutstanding; i++) begin : g_dec
    assign res_sel[i] = (res.id == X_ID_WIDTH'(i));
    assign cmt_sel[i] = (commit_id_i == X_ID_WIDTH'(i));
    assign iss_sel[i] = (issue_req_q.id == X_ID_WIDTH'(i));
  end

  always_comb begin
    alloc_id = '0;
    for (int i = NrOutstanding - 1; i >= 0; i--) begin
      if (!valid_q[i]) alloc_id = X_ID_WIDTH'(i);
    end
  end

  assign any_free        = ~&valid_q;
  assign off_ready_o     = (state_q == IDLE) && any_free;
  assign res_hs          = cvxif_resp_i.x_result_valid && wb_ready_i;
  assign kill_now        = commit_valid_i && commit_kill_i;
  // A kill arriving alongside its own result wins silently.
  assign kill_hit        = kill_now && (commit_id_i == res.id);
  assign res_entry_valid = |(res_sel & valid_q);
  assign cmt_entry_valid = |(cmt_sel & valid_q);
  assign res_deliver     = cvxif_resp_i.x_result_valid && res_entry_valid && !kill_hit;

  always_comb begin
    state_d       = state_q;
    issue_req_d   = issue_req_q;
    resp_valid_d  = 1'b0;
    resp_accept_d = resp_accept_q;
    resp_wb_d     = resp_wb_q;
    resp_id_d     = resp_id_q;
    valid_d       = valid_q;
    wb_d          = wb_q;
    err_d         = err_q;
    case (state_q)
      IDLE: begin
        if (off_valid_i && off_ready_o) begin
          issue_req_d.instr    = off_instr_i;
          issue_req_d.rs       = off_rs_i;
          issue_req_d.rs_valid = '1;
          issue_req_d.mode     = 2'b00;
          issue_req_d.id       = alloc_id;
          state_d              = ISSUE;
        end
      end
      ISSUE: begin
        if (cvxif_resp_i.x_issue_ready) begin
          state_d       = IDLE;
          resp_valid_d  = 1'b1;
          resp_accept_d = cvxif_resp_i.x_issue_resp.accept;
          resp_wb_d     = cvxif_resp_i.x_issue_resp.writeback;
          resp_id_d     = issue_req_q.id;
          if (cvxif_resp_i.x_issue_resp.accept) begin
            valid_d = valid_d | iss_sel;
            if (cvxif_resp_i.x_issue_resp.writeback) wb_d = wb_d | iss_sel;
            else                                     wb_d = wb_d & ~iss_sel;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (res_hs && res_deliver) valid_d = valid_d & ~res_sel;
    if (kill_now)              valid_d = valid_d & ~cmt_sel;
    if (commit_valid_i && !cmt_entry_valid)      err_d = 1'b1;
    if (res_hs && !res_entry_valid && !kill_hit) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= IDLE;
      issue_req_q    <= '0;
      valid_q        <= '0;
      wb_q           <= '0;
      resp_valid_q   <= 1'b0;
      resp_accept_q  <= 1'b0;
      resp_wb_q      <= 1'b0;
      resp_id_q      <= '0;
      commit_valid_q <= 1'b0;
      commit_q       <= '0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      issue_req_q    <= issue_req_d;
      valid_q        <= valid_d;
      wb_q           <= wb_d;
      resp_valid_q   <= resp_valid_d;
      resp_accept_q  <= resp_accept_d;
      resp_wb_q      <= resp_wb_d;
      resp_id_q      <= resp_id_d;
      commit_valid_q <= commit_valid_i;
      if (commit_valid_i) commit_q <= '{id: commit_id_i, commit_kill: commit_kill_i};
      err_q          <= err_d;
    end
  end

  assign off_resp_valid_o     = resp_valid_q;
  assign off_resp_accept_o    = resp_accept_q;
  assign off_resp_id_o        = resp_id_q;
  assign off_resp_writeback_o = resp_wb_q;
  assign err_o                = err_q;

  assign wb_valid_o   = res_deliver;
  assign wb_id_o      = res_deliver ? res.id : '0;
  assign wb_rd_o      = res_deliver ? res.rd : '0;
  assign wb_data_o    = res_deliver ? res.data : '0;
  assign wb_we_o      = res_deliver && res.we && |(res_sel & wb_q);
  assign wb_exc_o     = res_deliver && res.exc;
  assign wb_exccode_o = res_deliver ? res.exccode : '0;

  always_comb begin
    cvxif_req_o                = '0;
    cvxif_req_o.x_issue_valid  = (state_q == ISSUE);
    cvxif_req_o.x_issue_req    = issue_req_q;
    cvxif_req_o.x_commit_valid = commit_valid_q;
    cvxif_req_o.x_commit       = commit_q;
    cvxif_req_o.x_result_ready = wb_ready_i;
  end

  logic unused_resp;
  assign unused_resp = ^{cvxif_resp_i.x_compressed_ready, cvxif_resp_i.x_compressed_resp,
                         cvxif_resp_i.x_issue_resp.dualwrite, cvxif_resp_i.x_issue_resp.dualread,
                         cvxif_resp_i.x_issue_resp.loadstore, cvxif_resp_i.x_issue_resp.exc,
                         cvxif_resp_i.x_mem_valid, cvxif_resp_i.x_mem_req};

endmodule

// File: tb/tb_cvxif_offload_agent.sv
// Directed bench for cvxif_offload_agent; the bench plays both core and coprocessor.
module tb_cvxif_offload_agent;
  import cvxif_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                                 off_valid, off_ready;
  logic [31:0]                          off_instr;
  logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] off_rs;
  logic                                 off_resp_valid, off_resp_accept, off_resp_wb;
  logic [X_ID_WIDTH-1:0]                off_resp_id;
  logic                                 commit_valid, commit_kill;
  logic [X_ID_WIDTH-1:0]                commit_id;
  logic                                 wb_valid, wb_ready, wb_we, wb_exc, err;
  logic [X_ID_WIDTH-1:0]                wb_id;
  logic [4:0]                           wb_rd;
  logic [X_RFW_WIDTH-1:0]               wb_data;
  logic [5:0]                           wb_exccode;
  cvxif_req_t                           req;
  cvxif_resp_t                          resp;

  int checks = 0;
  int failures = 0;

  cvxif_offload_agent #(.NrOutstanding(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .off_valid_i(off_valid), .off_ready_o(off_ready), .off_instr_i(off_instr), .off_rs_i(off_rs),
    .off_resp_valid_o(off_resp_valid), .off_resp_accept_o(off_resp_accept),
    .off_resp_id_o(off_resp_id), .off_resp_writeback_o(off_resp_wb),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_id_o(wb_id), .wb_rd_o(wb_rd),
    .wb_data_o(wb_data), .wb_we_o(wb_we), .wb_exc_o(wb_exc), .wb_exccode_o(wb_exccode),
    .err_o(err), .cvxif_req_o(req), .cvxif_resp_i(resp)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    off_valid = 0; off_instr = '0; off_rs = '0;
    commit_valid = 0; commit_id = '0; commit_kill = 0;
    wb_ready = 0; resp = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    repeat (2) tick();
    rst_n = 1;
  endtask

  task automatic set_result(input logic [2:0] id, input logic [31:0] data, input logic we);
    resp.x_result_valid = 1; resp.x_result.id = id; resp.x_result.data = data;
    resp.x_result.we = we;   resp.x_result.rd = 5'd5;
  endtask

  // Runs one offload; ok collects the cycle-level timing expectations along the way.
  task automatic offload(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b,
                         input int delay, input logic acc, input logic wbk,
                         output bit ok, output x_issue_req_t rq, output logic rv,
                         output logic ra, output logic rw, output logic [2:0] rid);
    tick();
    ok = (off_ready === 1'b1) && (req.x_issue_valid === 1'b0);
    off_valid = 1; off_instr = instr; off_rs[0] = a; off_rs[1] = b;
    tick();
    off_valid = 0;
    ok = ok && (req.x_issue_valid === 1'b1) && (off_ready === 1'b0);
    rq = req.x_issue_req;
    for (int i = 0; i < delay; i++) begin
      tick();
      ok = ok && (req.x_issue_valid === 1'b1) && (req.x_issue_req === rq) && (off_resp_valid === 1'b0);
    end
    resp.x_issue_ready = 1; resp.x_issue_resp.accept = acc; resp.x_issue_resp.writeback = wbk;
    tick();
    resp.x_issue_ready = 0; resp.x_issue_resp = '0;
    ok = ok && (req.x_issue_valid === 1'b0);
    rv = off_resp_valid; ra = off_resp_accept; rw = off_resp_wb; rid = off_resp_id;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    repeat (2) tick();
    checks++; if (off_ready !== 1'b1) begin failures++; $display("FAIL rst_off_ready got=%0b exp=1", off_ready); end
    checks++; if (off_resp_valid !== 1'b0) begin failures++; $display("FAIL rst_off_resp_valid got=%0b exp=0", off_resp_valid); end
    checks++; if (req !== '0) begin failures++; $display("FAIL rst_req got=%0h exp=0", req); end
    checks++; if ({wb_valid, err, wb_data} !== '0) begin failures++; $display("FAIL rst_wb_err got=%0h exp=0", {wb_valid, err, wb_data}); end
    rst_n = 1;
  endtask

  task automatic test_basic();
    bit ok; x_issue_req_t rq; logic rv, ra, rw; logic [2:0] rid;
    do_reset();
    offload(32'h0000_000B, 32'd3, 32'd4, 1, 1, 1, ok, rq, rv, ra, rw, rid);
    checks++; if (!ok) begin failures++; $display("FAIL basic_issue_timing got=0 exp=1"); end
    checks++; if (rq.instr !== 32'h0000_000B) begin failures++; $display("FAIL basic_instr got=%0h exp=b", rq.instr); end
    checks++; if (rq.rs[0] !== 32'd3 || rq.rs[1] !== 32'd4) begin failures++; $display("FAIL basic_rs got=%0h,%0h exp=3,4", rq.rs[0], rq.rs[1]); end
    checks++; if (rq.rs_valid !== 2'b11 || rq.mode !== 2'b00 || rq.id !== 3'd0) begin failures++; $display("FAIL basic_req_fields got=%0b/%0d/%0d exp=11/0/0", rq.rs_valid, rq.mode, rq.id); end
    checks++; if ({rv, ra, rw, rid} !== {3'b111, 3'd0}) begin failures++; $display("FAIL basic_off_resp got=%0b%0b%0b id=%0d exp=111 id=0", rv, ra, rw, rid); end
    commit_valid = 1; commit_id = 0; commit_kill = 0;
    tick();
    checks++; if (off_resp_valid !== 1'b0) begin failures++; $display("FAIL basic_resp_pulse got=%0b exp=0", off_resp_valid); end
    commit_valid = 0;
    checks++; if (req.x_commit_valid !== 1'b1 || req.x_commit.id !== 3'd0 || req.x_commit.commit_kill !== 1'b0) begin failures++; $display("FAIL basic_commit got=%0b/%0d/%0b exp=1/0/0", req.x_commit_valid, req.x_commit.id, req.x_commit.commit_kill); end
    wb_ready = 1; set_result(3'd0, 32'd7, 1'b1);
    #1;
    checks++; if ({wb_valid, wb_we, wb_id, wb_rd} !== {2'b11, 3'd0, 5'd5}) begin failures++; $display("FAIL basic_wb_ctrl got=%0b%0b id=%0d rd=%0d exp=11 id=0 rd=5", wb_valid, wb_we, wb_id, wb_rd); end
    checks++; if (wb_data !== 32'd7) begin failures++; $display("FAIL basic_wb_data got=%0d exp=7", wb_data); end
    tick();
    resp.x_result_valid = 0; wb_ready = 0;
    checks++; if (req.x_commit_valid !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL basic_after got=%0b/%0b exp=0/0", req.x_commit_valid, err); end
  endtask

  task automatic test_reject();
    bit ok; x_issue_req_t rq; logic rv, ra, rw; logic [2:0] rid;
    do_reset();
    offload(32'h0000_002B, 32'd1, 32'd2, 0, 0, 1, ok, rq, rv, ra, rw, rid);
    checks++; if (!ok || rv !== 1'b1 || ra !== 1'b0) begin failures++; $display("FAIL reject_accept got=ok%0b v%0b a%0b exp=ok1 v1 a0", ok, rv, ra); end
    offload(32'h0000_002B, 32'd1, 32'd2, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    checks++; if (rid !== 3'd0 || ra !== 1'b1) begin failures++; $display("FAIL reject_next_id got=%0d/%0b exp=0/1", rid, ra); end
  endtask

  task automatic test_full();
    bit ok; x_issue_req_t rq; logic rv, ra, rw; logic [2:0] rid;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      offload(32'h0000_100B + i, i, i, 0, 1, 0, ok, rq, rv, ra, rw, rid);
      checks++; if (rid !== 3'(i) || !ok) begin failures++; $display("FAIL full_alloc_%0d got=%0d ok=%0b exp=%0d ok=1", i, rid, ok, i); end
    end
    tick();
    checks++; if (off_ready !== 1'b0) begin failures++; $display("FAIL full_ready_low got=%0b exp=0", off_ready); end
    wb_ready = 1; set_result(3'd2, 32'h22, 1'b1);
    #1;
    checks++; if ({wb_valid, wb_we, off_ready} !== 3'b100) begin failures++; $display("FAIL full_result_we got=%0b%0b%0b exp=100", wb_valid, wb_we, off_ready); end
    tick();
    resp.x_result_valid = 0; wb_ready = 0;
    checks++; if (off_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%0b exp=1", off_ready); end
    offload(32'h0000_200B, 0, 0, 0, 1, 0, ok, rq, rv, ra, rw, rid);
    checks++; if (rid !== 3'd2) begin failures++; $display("FAIL full_realloc got=%0d exp=2", rid); end
  endtask

  task automatic test_kill_result();
    bit ok; x_issue_req_t rq; logic rv, ra, rw; logic [2:0] rid;
    do_reset();
    offload(32'h0000_000B, 0, 0, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    offload(32'h0000_000B, 0, 0, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    tick();
    commit_valid = 1; commit_id = 3'd1; commit_kill = 1;
    wb_ready = 1; set_result(3'd1, 32'd9, 1'b1);
    #1;
    checks++; if (wb_valid !== 1'b0 || req.x_result_ready !== 1'b1) begin failures++; $display("FAIL kill_drop got=%0b/%0b exp=0/1", wb_valid, req.x_result_ready); end
    tick();
    commit_valid = 0; commit_kill = 0; resp.x_result_valid = 0; wb_ready = 0;
    checks++; if ({err, req.x_commit_valid, req.x_commit.commit_kill, req.x_commit.id} !== {3'b011, 3'd1}) begin failures++; $display("FAIL kill_fwd got=e%0b v%0b k%0b id%0d exp=e0 v1 k1 id1", err, req.x_commit_valid, req.x_commit.commit_kill, req.x_commit.id); end
    offload(32'h0000_000B, 0, 0, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    checks++; if (rid !== 3'd1) begin failures++; $display("FAIL kill_freed got=%0d exp=1", rid); end
  endtask

  task automatic test_backpressure();
    bit ok; x_issue_req_t rq; logic rv, ra, rw; logic [2:0] rid;
    do_reset();
    offload(32'h0000_000B, 0, 0, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    tick();
    wb_ready = 0; set_result(3'd0, 32'h55, 1'b1);
    #1;
    checks++; if (req.x_result_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%0b exp=0", req.x_result_ready); end
    tick();
    wb_ready = 1;
    #1;
    checks++; if ({req.x_result_ready, wb_valid, wb_we} !== 3'b111 || wb_data !== 32'h55) begin failures++; $display("FAIL bp_deliver got=%0b%0b%0b d=%0h exp=111 d=55", req.x_result_ready, wb_valid, wb_we, wb_data); end
    tick();
    resp.x_result_valid = 0; wb_ready = 0;
    offload(32'h0000_000B, 0, 0, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    checks++; if (rid !== 3'd0 || err !== 1'b0) begin failures++; $display("FAIL bp_freed got=%0d err=%0b exp=0 err=0", rid, err); end
  endtask

  task automatic test_back_to_back();
    bit ok; x_issue_req_t rq; logic rv, ra, rw; logic [2:0] rid;
    do_reset();
    for (int i = 0; i < 3; i++) offload(32'h0000_000B, 0, 0, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    tick();
    off_valid = 1;
    tick();
    off_valid = 0;
    resp.x_issue_ready = 1; resp.x_issue_resp.accept = 1; resp.x_issue_resp.writeback = 1;
    wb_ready = 1; set_result(3'd0, 32'd3, 1'b0);
    #1;
    checks++; if (wb_valid !== 1'b1 || off_ready !== 1'b0) begin failures++; $display("FAIL b2b_same_cycle got=%0b/%0b exp=1/0", wb_valid, off_ready); end
    tick();
    resp = '0; wb_ready = 0;
    checks++; if ({off_resp_valid, off_resp_accept, off_resp_id, off_ready} !== {2'b11, 3'd3, 1'b1}) begin failures++; $display("FAIL b2b_resp got=%0b%0b id=%0d rdy=%0b exp=11 id=3 rdy=1", off_resp_valid, off_resp_accept, off_resp_id, off_ready); end
    offload(32'h0000_000B, 0, 0, 0, 1, 1, ok, rq, rv, ra, rw, rid);
    checks++; if (rid !== 3'd0 || off_ready !== 1'b0) begin failures++; $display("FAIL b2b_realloc got=%0d rdy=%0b exp=0 rdy=0", rid, off_ready); end
  endtask

  task automatic test_error();
    do_reset();
    tick();
    wb_ready = 1; set_result(3'd3, 32'hDEAD, 1'b1);
    #1;
    checks++; if (wb_valid !== 1'b0) begin failures++; $display("FAIL err_drop got=%0b exp=0", wb_valid); end
    tick();
    resp.x_result_valid = 0; wb_ready = 0;
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_set got=%0b exp=1", err); end
    repeat (3) tick();
    checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky got=%0b exp=1", err); end
    do_reset();
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL err_reset got=%0b exp=0", err); end
    commit_valid = 1; commit_id = 3'd2; commit_kill = 0;
    tick();
    commit_valid = 0;
    checks++; if ({req.x_commit_valid, req.x_commit.id, err} !== {1'b1, 3'd2, 1'b1}) begin failures++; $display("FAIL err_commit got=v%0b id%0d e%0b exp=v1 id2 e1", req.x_commit_valid, req.x_commit.id, err); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_full();
    test_kill_result();
    test_backpressure();
    test_back_to_back();
    test_error();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
